// File: rtl/l2_arbiter.sv
// ---------------------------------------------------------------------------
// l2_arbiter
//
// Shares the single L2 line port between the L1 I-cache miss path (read
// only) and the L1 D-cache miss/writeback path (read/write). One L2
// transaction is in flight at a time. The winner's address, write data and
// operation are latched at grant. The L2 response is routed back to the
// winner only. Round-robin priority keeps either side from starving.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   i_read      I-side line-read request, held until i_resp
//   i_address   I-side line address
//   i_rdata     I-side read data, updated only on the I completion
//   i_resp      I-side one-cycle completion pulse
//   d_read      D-side line-read request, held until d_resp
//   d_write     D-side writeback request, held until d_resp
//   d_address   D-side line address
//   d_wdata     D-side write data
//   d_rdata     D-side read data, updated only on the D completion
//   d_resp      D-side one-cycle completion pulse
//   l2_read     read request to L2
//   l2_write    write request to L2
//   l2_address  latched address to L2
//   l2_wdata    latched write data to L2
//   l2_rdata    L2 read data, valid with l2_resp
//   l2_resp     L2 completion pulse
//   last_grant  side served last (0 = I, 1 = D)
// ---------------------------------------------------------------------------
module l2_arbiter #(
    parameter int s_line = 256,
    parameter int s_addr = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_read,
    input  logic [s_addr-1:0] i_address,
    output logic [s_line-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [s_addr-1:0] d_address,
    input  logic [s_line-1:0] d_wdata,
    output logic [s_line-1:0] d_rdata,
    output logic              d_resp,
    output logic              l2_read,
    output logic              l2_write,
    output logic [s_addr-1:0] l2_address,
    output logic [s_line-1:0] l2_wdata,
    input  logic [s_line-1:0] l2_rdata,
    input  logic              l2_resp,
    output logic              last_grant
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t state_r;

    logic i_req_s;
    logic d_req_s;
    logic grant_d_s;

    // Request decode and round-robin choice. On a conflict the side that
    // was not served last wins, so after reset (last_grant = 0) D goes first.
    always_comb begin
        i_req_s   = i_read;
        d_req_s   = d_read | d_write;
        grant_d_s = d_req_s & (~i_req_s | ~last_grant);
    end

    // Transaction sequencer with all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            l2_read    <= 1'b0;
            l2_write   <= 1'b0;
            l2_address <= {s_addr{1'b0}};
            l2_wdata   <= {s_line{1'b0}};
            i_rdata    <= {s_line{1'b0}};
            d_rdata    <= {s_line{1'b0}};
            i_resp     <= 1'b0;
            d_resp     <= 1'b0;
            last_grant <= 1'b0;
        end else begin
            // Completion pulses last exactly one cycle (the RELEASE cycle).
            i_resp <= 1'b0;
            d_resp <= 1'b0;
            case (state_r)
                IDLE: begin
                    // A stray l2_resp here (e.g. after a mid-transaction
                    // reset) is deliberately ignored.
                    if (grant_d_s) begin
                        l2_address <= d_address;
                        l2_wdata   <= d_wdata;
                        // Write wins if both read and write are requested.
                        l2_write   <= d_write;
                        l2_read    <= ~d_write;
                        last_grant <= 1'b1;
                        state_r    <= SERVE_D;
                    end else if (i_req_s) begin
                        l2_address <= i_address;
                        l2_write   <= 1'b0;
                        l2_read    <= 1'b1;
                        last_grant <= 1'b0;
                        state_r    <= SERVE_I;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                SERVE_I: begin
                    if (l2_resp) begin
                        i_rdata  <= l2_rdata;
                        i_resp   <= 1'b1;
                        l2_read  <= 1'b0;
                        l2_write <= 1'b0;
                        state_r  <= RELEASE;
                    end else begin
                        state_r  <= SERVE_I;
                    end
                end
                SERVE_D: begin
                    if (l2_resp) begin
                        // Captured on writes too; L2 defines the value.
                        d_rdata  <= l2_rdata;
                        d_resp   <= 1'b1;
                        l2_read  <= 1'b0;
                        l2_write <= 1'b0;
                        state_r  <= RELEASE;
                    end else begin
                        state_r  <= SERVE_D;
                    end
                end
                RELEASE: begin
                    // Requests are not sampled here so the served side has
                    // one cycle to drop its still-asserted request.
                    state_r <= IDLE;
                end
                default: begin
                    l2_read  <= 1'b0;
                    l2_write <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_arbiter.sv
module tb_l2_arbiter;

    logic         clk;
    logic         reset;
    logic         i_read;
    logic [31:0]  i_address;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_address;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         l2_read;
    logic         l2_write;
    logic [31:0]  l2_address;
    logic [255:0] l2_wdata;
    logic [255:0] l2_rdata;
    logic         l2_resp;
    logic         last_grant;

    int errors = 0;
    int checks = 0;

    l2_arbiter #(.s_line(256), .s_addr(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_read     (i_read),
        .i_address  (i_address),
        .i_rdata    (i_rdata),
        .i_resp     (i_resp),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_address  (d_address),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_resp     (d_resp),
        .l2_read    (l2_read),
        .l2_write   (l2_write),
        .l2_address (l2_address),
        .l2_wdata   (l2_wdata),
        .l2_rdata   (l2_rdata),
        .l2_resp    (l2_resp),
        .last_grant (last_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold off L2 for wait_cycles edges (no response may appear), then
    // return data with a one-cycle l2_resp. Returns in the RELEASE cycle.
    task automatic serve(input logic [255:0] data, input int wait_cycles);
        for (int w = 0; w < wait_cycles; w++) begin
            tick();
            check("no_early_resp", {255'd0, i_resp | d_resp}, 256'd0);
            check("rw_exclusive", {255'd0, l2_read & l2_write}, 256'd0);
        end
        l2_rdata = data;
        l2_resp  = 1'b1;
        tick();
        l2_resp  = 1'b0;
        l2_rdata = {256{1'b0}};
    endtask

    logic [255:0] pat_a5;
    logic [255:0] pat_1234;
    logic [255:0] pat_d;
    logic [255:0] pat_i;
    logic [255:0] pat_w;
    logic [255:0] pat_f;
    logic         exp_d;

    initial begin
        pat_a5   = {32{8'hA5}};
        pat_1234 = {16{16'h1234}};
        pat_d    = {8{32'hDDDD_0001}};
        pat_i    = {8{32'h1111_0002}};
        pat_w    = {8{32'hCAFE_F00D}};
        reset     = 1'b0;
        i_read    = 1'b0;
        i_address = 32'd0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        d_address = 32'd0;
        d_wdata   = {256{1'b0}};
        l2_rdata  = {256{1'b0}};
        l2_resp   = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_l2_read", {255'd0, l2_read}, 256'd0);
        check("rst_l2_write", {255'd0, l2_write}, 256'd0);
        check("rst_l2_address", {224'd0, l2_address}, 256'd0);
        check("rst_i_rdata", i_rdata, 256'd0);
        check("rst_d_resp", {255'd0, d_resp}, 256'd0);
        check("rst_last_grant", {255'd0, last_grant}, 256'd0);
        reset = 1'b1;
        tick();

        // Single I read, L2 answers 5 cycles after the request.
        i_read    = 1'b1;
        i_address = 32'h0000_1000;
        tick();
        check("i1_l2_read", {255'd0, l2_read}, 256'd1);
        check("i1_l2_write", {255'd0, l2_write}, 256'd0);
        check("i1_l2_address", {224'd0, l2_address}, 256'h1000);
        serve(pat_a5, 4);
        check("i1_i_resp", {255'd0, i_resp}, 256'd1);
        check("i1_i_rdata", i_rdata, pat_a5);
        check("i1_d_resp", {255'd0, d_resp}, 256'd0);
        check("i1_d_rdata", d_rdata, 256'd0);
        check("i1_l2_read_drop", {255'd0, l2_read}, 256'd0);
        check("i1_last_grant", {255'd0, last_grant}, 256'd0);
        i_read = 1'b0;
        tick();
        check("i1_resp_one_cycle", {255'd0, i_resp}, 256'd0);
        check("i1_rdata_hold", i_rdata, pat_a5);
        tick();

        // D writeback, L2 answers 3 cycles after the request.
        d_write   = 1'b1;
        d_address = 32'h0000_2020;
        d_wdata   = pat_1234;
        tick();
        check("dw_l2_write", {255'd0, l2_write}, 256'd1);
        check("dw_l2_read", {255'd0, l2_read}, 256'd0);
        check("dw_l2_wdata", l2_wdata, pat_1234);
        check("dw_l2_address", {224'd0, l2_address}, 256'h2020);
        check("dw_last_grant", {255'd0, last_grant}, 256'd1);
        serve(pat_w, 2);
        check("dw_d_resp", {255'd0, d_resp}, 256'd1);
        check("dw_i_resp", {255'd0, i_resp}, 256'd0);
        check("dw_d_rdata", d_rdata, pat_w);
        check("dw_i_rdata_hold", i_rdata, pat_a5);
        d_write = 1'b0;
        tick();
        check("dw_resp_one_cycle", {255'd0, d_resp}, 256'd0);
        tick();

        // Simultaneous requests straight after reset: D first, then I.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        i_read    = 1'b1;
        i_address = 32'h0000_3000;
        d_read    = 1'b1;
        d_address = 32'h0000_4000;
        tick();
        check("sim_first_addr", {224'd0, l2_address}, 256'h4000);
        check("sim_first_grant", {255'd0, last_grant}, 256'd1);
        check("sim_first_read", {255'd0, l2_read}, 256'd1);
        serve(pat_d, 1);
        check("sim_d_resp", {255'd0, d_resp}, 256'd1);
        check("sim_i_no_resp", {255'd0, i_resp}, 256'd0);
        d_read = 1'b0;
        tick();
        check("sim_release_idle", {255'd0, l2_read}, 256'd0);
        tick();
        check("sim_second_addr", {224'd0, l2_address}, 256'h3000);
        check("sim_second_grant", {255'd0, last_grant}, 256'd0);
        serve(pat_i, 1);
        check("sim_i_resp", {255'd0, i_resp}, 256'd1);
        check("sim_i_rdata", i_rdata, pat_i);
        i_read = 1'b0;
        tick();
        tick();

        // Fairness: both request continuously; expect D, I, D, I, D, I.
        i_read    = 1'b1;
        i_address = 32'h0000_5000;
        d_read    = 1'b1;
        d_address = 32'h0000_6000;
        for (int k = 0; k < 6; k++) begin
            exp_d = (k % 2 == 0);
            pat_f = {8{32'h0F00_0000 + 32'(k)}};
            tick();
            check("fair_grant", {255'd0, last_grant}, {255'd0, exp_d});
            check("fair_addr", {224'd0, l2_address}, exp_d ? 256'h6000 : 256'h5000);
            serve(pat_f, 0);
            check("fair_d_resp", {255'd0, d_resp}, {255'd0, exp_d});
            check("fair_i_resp", {255'd0, i_resp}, {255'd0, ~exp_d});
            check("fair_rdata", exp_d ? d_rdata : i_rdata, pat_f);
            tick();
        end
        i_read = 1'b0;
        d_read = 1'b0;
        tick();
        tick();

        // Reset in the middle of an I transaction.
        i_read    = 1'b1;
        i_address = 32'h0000_7000;
        tick();
        check("mr_serve_read", {255'd0, l2_read}, 256'd1);
        tick();
        reset = 1'b0;
        #1;
        check("mr_l2_read", {255'd0, l2_read}, 256'd0);
        check("mr_l2_address", {224'd0, l2_address}, 256'd0);
        check("mr_i_rdata", i_rdata, 256'd0);
        check("mr_d_rdata", d_rdata, 256'd0);
        check("mr_last_grant", {255'd0, last_grant}, 256'd0);
        i_read = 1'b0;
        tick();
        reset    = 1'b1;
        l2_rdata = pat_a5;
        l2_resp  = 1'b1;
        tick();
        l2_resp  = 1'b0;
        check("mr_no_i_resp", {255'd0, i_resp}, 256'd0);
        check("mr_i_rdata_kept", i_rdata, 256'd0);
        check("mr_idle_read", {255'd0, l2_read}, 256'd0);
        tick();

        // d_read and d_write together; address change during SERVE_D.
        d_read    = 1'b1;
        d_write   = 1'b1;
        d_address = 32'h0000_0040;
        d_wdata   = pat_w;
        tick();
        check("cf_l2_write", {255'd0, l2_write}, 256'd1);
        check("cf_l2_read", {255'd0, l2_read}, 256'd0);
        check("cf_addr", {224'd0, l2_address}, 256'h40);
        d_address = 32'h0000_0080;
        d_wdata   = pat_1234;
        tick();
        check("cf_addr_held", {224'd0, l2_address}, 256'h40);
        check("cf_wdata_held", l2_wdata, pat_w);
        serve(pat_d, 1);
        check("cf_d_resp", {255'd0, d_resp}, 256'd1);
        check("cf_addr_at_resp", {224'd0, l2_address}, 256'h40);
        check("cf_write_drop", {255'd0, l2_write}, 256'd0);
        d_read  = 1'b0;
        d_write = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
